// File: rtl/sprite_pkg.sv
// Shared widths, table entry layout and scheduler state encoding for the
// per-frame sprite scheduler.
package sprite_pkg;

    localparam int CANVAS_WIDTH  = 360;
    localparam int CANVAS_HEIGHT = 720;
    localparam int NUM_FRAMES    = 18;

    localparam int X_W = $clog2(CANVAS_WIDTH);
    localparam int Y_W = $clog2(CANVAS_HEIGHT);
    localparam int F_W = $clog2(NUM_FRAMES);

    typedef struct packed {
        logic           active;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [F_W-1:0] frame;
    } sprite_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SCAN      = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_GAP       = 3'd3,
        ST_WAIT_DONE = 3'd4
    } sched_state_t;

endpackage

// File: rtl/sprite_table.sv
// Sprite entry register file: one synchronous write port, one combinational
// read port. Reset empties the table.
module sprite_table
    import sprite_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic            clk_pixel,
    input  logic            sys_rst,
    input  logic            wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  sprite_entry_t   wr_entry,
    input  logic [IDX_W-1:0] rd_index,
    output sprite_entry_t   rd_entry
);

    sprite_entry_t table_r [DEPTH];

    // Entry storage; writes land the cycle after wr_en.
    always_ff @(posedge clk_pixel or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_r[i] <= '0;
            end
        end else if (wr_en) begin
            table_r[wr_index] <= wr_entry;
        end
    end

    assign rd_entry = table_r[rd_index];

endmodule

// File: rtl/sprite_scheduler.sv
// Walks the sprite table once per new frame and hands each active entry to the
// graphics block over a valid/ready handshake; later indices are drawn on top.
module sprite_scheduler
    import sprite_pkg::*;
#(
    parameter int MAX_SPRITES = 16,
    localparam int IDX_W      = $clog2(MAX_SPRITES)
) (
    input  logic             clk_pixel,
    input  logic             sys_rst,
    input  logic [5:0]       frame_count,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic             wr_active,
    input  logic [X_W-1:0]   wr_x,
    input  logic [Y_W-1:0]   wr_y,
    input  logic [F_W-1:0]   wr_frame,
    input  logic             sprite_ready,
    output logic             sprite_valid,
    output logic [X_W-1:0]   sprite_x,
    output logic [Y_W-1:0]   sprite_y,
    output logic [F_W-1:0]   sprite_frame_number,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun,
    output logic [IDX_W:0]   drawn_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_SPRITES - 1);

    sched_state_t     state_r;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W:0]   cnt_r;
    logic [5:0]       prev_fc_r;
    logic             pending_r;
    logic             new_frame_s;
    logic             last_s;
    logic             in_handshake_s;
    sprite_entry_t    wr_entry_s;
    sprite_entry_t    rd_entry_s;

    assign new_frame_s    = (frame_count != prev_fc_r);
    assign last_s         = (idx_r == LAST_IDX);
    assign in_handshake_s = (state_r == ST_ISSUE) || (state_r == ST_GAP) ||
                            (state_r == ST_WAIT_DONE);
    assign wr_entry_s     = '{active: wr_active, x: wr_x, y: wr_y, frame: wr_frame};

    sprite_table #(
        .DEPTH (MAX_SPRITES),
        .IDX_W (IDX_W)
    ) u_table (
        .clk_pixel (clk_pixel),
        .sys_rst   (sys_rst),
        .wr_en     (wr_en),
        .wr_index  (wr_index),
        .wr_entry  (wr_entry_s),
        .rd_index  (idx_r),
        .rd_entry  (rd_entry_s)
    );

    // Scheduler FSM with all handshake and status outputs registered.
    always_ff @(posedge clk_pixel or posedge sys_rst) begin
        if (sys_rst) begin
            state_r             <= ST_IDLE;
            idx_r               <= '0;
            cnt_r               <= '0;
            prev_fc_r           <= frame_count;
            pending_r           <= 1'b0;
            sprite_valid        <= 1'b0;
            sprite_x            <= '0;
            sprite_y            <= '0;
            sprite_frame_number <= '0;
            busy                <= 1'b0;
            frame_done          <= 1'b0;
            overrun             <= 1'b0;
            drawn_count         <= '0;
        end else begin
            prev_fc_r    <= frame_count;
            sprite_valid <= 1'b0;
            frame_done   <= 1'b0;
            overrun      <= 1'b0;

            // A frame arriving mid-pass is flagged; inside a handshake the
            // restart must wait until the graphics block is released.
            if (new_frame_s && (state_r != ST_IDLE)) begin
                overrun <= 1'b1;
            end
            if (new_frame_s && in_handshake_s) begin
                pending_r <= 1'b1;
            end

            case (state_r)
                ST_IDLE: begin
                    if (new_frame_s) begin
                        state_r <= ST_SCAN;
                        idx_r   <= '0;
                        cnt_r   <= '0;
                        busy    <= 1'b1;
                    end
                end

                ST_SCAN: begin
                    if (new_frame_s) begin
                        idx_r <= '0;
                        cnt_r <= '0;
                    end else if (!rd_entry_s.active) begin
                        if (last_s) begin
                            state_r     <= ST_IDLE;
                            frame_done  <= 1'b1;
                            drawn_count <= cnt_r;
                            busy        <= 1'b0;
                        end else begin
                            idx_r <= idx_r + IDX_W'(1);
                        end
                    end else if (sprite_ready) begin
                        sprite_x            <= rd_entry_s.x;
                        sprite_y            <= rd_entry_s.y;
                        sprite_frame_number <= rd_entry_s.frame;
                        sprite_valid        <= 1'b1;
                        state_r             <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    cnt_r   <= cnt_r + (IDX_W + 1)'(1);
                    state_r <= ST_GAP;
                end

                // sprite_ready is still the stale idle level here.
                ST_GAP: begin
                    state_r <= ST_WAIT_DONE;
                end

                ST_WAIT_DONE: begin
                    if (sprite_ready) begin
                        if (pending_r || new_frame_s) begin
                            pending_r <= 1'b0;
                            idx_r     <= '0;
                            cnt_r     <= '0;
                            state_r   <= ST_SCAN;
                        end else if (last_s) begin
                            state_r     <= ST_IDLE;
                            frame_done  <= 1'b1;
                            drawn_count <= cnt_r;
                            busy        <= 1'b0;
                        end else begin
                            idx_r   <= idx_r + IDX_W'(1);
                            state_r <= ST_SCAN;
                        end
                    end
                end

                default: begin
                    state_r   <= ST_IDLE;
                    busy      <= 1'b0;
                    pending_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed bench for sprite_scheduler: the graphics block is modelled by
// dropping sprite_ready for a fixed hold after every accepted sprite.
module tb_sprite_scheduler;
    import sprite_pkg::*;

    localparam int IW = 4;

    logic            clk_pixel = 1'b0;
    logic            sys_rst;
    logic [5:0]      frame_count;
    logic            wr_en;
    logic [IW-1:0]   wr_index;
    logic            wr_active;
    logic [X_W-1:0]  wr_x;
    logic [Y_W-1:0]  wr_y;
    logic [F_W-1:0]  wr_frame;
    logic            sprite_ready;
    logic            sprite_valid;
    logic [X_W-1:0]  sprite_x;
    logic [Y_W-1:0]  sprite_y;
    logic [F_W-1:0]  sprite_frame_number;
    logic            busy;
    logic            frame_done;
    logic            overrun;
    logic [IW:0]     drawn_count;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int got_x[$];
    int got_f[$];
    int viol;
    int ovr_seen;
    int n;
    int cyc;
    int cnt_bad;
    logic done;

    sprite_scheduler #(.MAX_SPRITES(16)) dut (
        .clk_pixel           (clk_pixel),
        .sys_rst             (sys_rst),
        .frame_count         (frame_count),
        .wr_en               (wr_en),
        .wr_index            (wr_index),
        .wr_active           (wr_active),
        .wr_x                (wr_x),
        .wr_y                (wr_y),
        .wr_frame            (wr_frame),
        .sprite_ready        (sprite_ready),
        .sprite_valid        (sprite_valid),
        .sprite_x            (sprite_x),
        .sprite_y            (sprite_y),
        .sprite_frame_number (sprite_frame_number),
        .busy                (busy),
        .frame_done          (frame_done),
        .overrun             (overrun),
        .drawn_count         (drawn_count)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic write_entry(input int idx, input int act, input int x, input int y, input int f);
        wr_en     = 1'b1;
        wr_index  = IW'(idx);
        wr_active = act[0];
        wr_x      = X_W'(x);
        wr_y      = Y_W'(y);
        wr_frame  = F_W'(f);
        tick();
        wr_en     = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!sprite_valid && cycles < budget);
        check(tag, {31'd0, sprite_valid}, 32'd1);
    endtask

    // Graphics model: accept each sprite, hold ready low for 'hold' cycles.
    task automatic run_gfx(input int hold, input int init_cd, input int budget,
                           output int cycles, output logic fin);
        int cd;
        cd = init_cd;
        cycles = 0;
        fin = 1'b0;
        got_x.delete();
        got_f.delete();
        viol = 0;
        ovr_seen = 0;
        while (!fin && cycles < budget) begin
            tick();
            cycles++;
            if (overrun) ovr_seen++;
            if (sprite_valid) begin
                if (!sprite_ready) viol++;
                got_x.push_back(int'(sprite_x));
                got_f.push_back(int'(sprite_frame_number));
                sprite_ready = 1'b0;
                cd = hold;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) sprite_ready = 1'b1;
            end
            if (frame_done) fin = 1'b1;
        end
    endtask

    function automatic int qx(input int i);
        return (i < got_x.size()) ? got_x[i] : -1;
    endfunction

    function automatic int qf(input int i);
        return (i < got_f.size()) ? got_f[i] : -1;
    endfunction

    initial begin
        sys_rst = 1'b1;
        frame_count = 6'd0;
        wr_en = 1'b0;
        wr_index = '0;
        wr_active = 1'b0;
        wr_x = '0;
        wr_y = '0;
        wr_frame = '0;
        sprite_ready = 1'b0;
        tick(); tick(); tick();
        sys_rst = 1'b0;
        tick();
        check("rst_valid", {31'd0, sprite_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_drawn", 32'(drawn_count), 32'd0);

        // Empty table: 16 inactive scans then completion.
        frame_count = 6'd1;
        run_gfx(64, 0, 40, cyc, done);
        check("empty_done", {31'd0, done}, 32'd1);
        check("empty_latency", 32'(cyc), 32'd17);
        check("empty_drawn", 32'(drawn_count), 32'd0);
        check("empty_busy", {31'd0, busy}, 32'd0);
        tick();
        check("empty_done_pulse", {31'd0, frame_done}, 32'd0);

        // Single sprite at entry 3.
        write_entry(3, 1, 100, 200, 5);
        sprite_ready = 1'b1;
        frame_count = 6'd2;
        wait_valid("e3_valid", 20, n);
        check("e3_latency", 32'(n), 32'd5);
        check("e3_x", 32'(sprite_x), 32'd100);
        check("e3_y", 32'(sprite_y), 32'd200);
        check("e3_f", 32'(sprite_frame_number), 32'd5);
        sprite_ready = 1'b0;
        tick();
        check("e3_valid_pulse", {31'd0, sprite_valid}, 32'd0);
        cnt_bad = 0;
        for (int i = 0; i < 4100; i++) begin
            tick();
            if (sprite_valid || frame_done) cnt_bad++;
        end
        check("e3_hold_quiet", 32'(cnt_bad), 32'd0);
        sprite_ready = 1'b1;
        run_gfx(64, 0, 40, cyc, done);
        check("e3_done", {31'd0, done}, 32'd1);
        check("e3_tail_cycles", 32'(cyc), 32'd13);
        check("e3_no_more", 32'(got_x.size()), 32'd0);
        check("e3_drawn", 32'(drawn_count), 32'd1);
        check("e3_x_hold", 32'(sprite_x), 32'd100);

        // Entries 0, 5, 15 with a slow graphics block.
        write_entry(3, 0, 100, 200, 5);
        write_entry(0, 1, 0, 0, 0);
        write_entry(5, 1, 100, 200, 5);
        write_entry(15, 1, 300, 600, 15);
        sprite_ready = 1'b1;
        frame_count = 6'd3;
        run_gfx(4096, 0, 20000, cyc, done);
        check("three_done", {31'd0, done}, 32'd1);
        check("three_count", 32'(got_x.size()), 32'd3);
        check("three_x0", 32'(qx(0)), 32'd0);
        check("three_x1", 32'(qx(1)), 32'd100);
        check("three_x2", 32'(qx(2)), 32'd300);
        check("three_f2", 32'(qf(2)), 32'd15);
        check("three_ready_viol", 32'(viol), 32'd0);
        check("three_drawn", 32'(drawn_count), 32'd3);
        check("three_overrun", 32'(ovr_seen), 32'd0);

        // Table edits during the WAIT_DONE of entry 0.
        frame_count = 6'd4;
        wait_valid("edit_valid", 20, n);
        check("edit_first_x", 32'(sprite_x), 32'd0);
        sprite_ready = 1'b0;
        tick(); tick();
        write_entry(10, 1, 200, 400, 10);
        write_entry(0, 0, 0, 0, 0);
        check("edit_x_latched", 32'(sprite_x), 32'd0);
        run_gfx(64, 3, 2000, cyc, done);
        check("edit_done", {31'd0, done}, 32'd1);
        check("edit_count", 32'(got_x.size()), 32'd3);
        check("edit_x0", 32'(qx(0)), 32'd100);
        check("edit_x1", 32'(qx(1)), 32'd200);
        check("edit_x2", 32'(qx(2)), 32'd300);
        check("edit_drawn", 32'(drawn_count), 32'd4);
        frame_count = 6'd5;
        run_gfx(64, 0, 2000, cyc, done);
        check("next_count", 32'(got_x.size()), 32'd3);
        check("next_x0", 32'(qx(0)), 32'd100);
        check("next_drawn", 32'(drawn_count), 32'd3);

        // New frames while entry 5 is in WAIT_DONE.
        frame_count = 6'd6;
        wait_valid("ovr_valid", 30, n);
        check("ovr_latency", 32'(n), 32'd7);
        sprite_ready = 1'b0;
        tick(); tick(); tick();
        frame_count = 6'd7;
        tick();
        check("ovr_pulse1", {31'd0, overrun}, 32'd1);
        check("ovr_drawn_kept", 32'(drawn_count), 32'd3);
        tick();
        check("ovr_pulse1_end", {31'd0, overrun}, 32'd0);
        cnt_bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sprite_valid || frame_done) cnt_bad++;
        end
        check("ovr_quiet", 32'(cnt_bad), 32'd0);
        frame_count = 6'd8;
        tick();
        check("ovr_pulse2", {31'd0, overrun}, 32'd1);
        sprite_ready = 1'b1;
        wait_valid("restart_valid", 30, n);
        check("restart_latency", 32'(n), 32'd7);
        check("restart_x", 32'(sprite_x), 32'd100);
        sprite_ready = 1'b0;
        run_gfx(64, 64, 3000, cyc, done);
        check("restart_done", {31'd0, done}, 32'd1);
        check("restart_count", 32'(got_x.size()), 32'd2);
        check("restart_x0", 32'(qx(0)), 32'd200);
        check("restart_x1", 32'(qx(1)), 32'd300);
        check("restart_drawn", 32'(drawn_count), 32'd3);
        check("restart_single", 32'(ovr_seen), 32'd0);

        // Asynchronous reset in the middle of a handshake.
        frame_count = 6'd9;
        wait_valid("arst_valid", 30, n);
        sprite_ready = 1'b0;
        tick(); tick(); tick();
        #2;
        sys_rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_x", 32'(sprite_x), 32'd0);
        check("arst_drawn", 32'(drawn_count), 32'd0);
        check("arst_valid0", {31'd0, sprite_valid}, 32'd0);
        tick();
        sys_rst = 1'b0;
        sprite_ready = 1'b1;
        frame_count = 6'd10;
        run_gfx(64, 0, 40, cyc, done);
        check("arst_empty_done", {31'd0, done}, 32'd1);
        check("arst_empty_cycles", 32'(cyc), 32'd17);
        check("arst_no_issue", 32'(got_x.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
